// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: direct-mapped BTB with 2-bit saturating
// counters, looked up combinationally with the fetch PC. Each prediction
// travels F->D->E alongside the instruction and is resolved in EX, where a
// misprediction flag and a correction PC are produced. Branches retiring
// through EX update or allocate BTB entries. After reset the table is swept
// invalid one entry per cycle before predictions are enabled.
//
// Ports:
//   clk, rst_n        core clock, synchronous active-low reset
//   PCF               fetch PC used for the BTB lookup
//   PCE               EX-stage PC of the resolving instruction
//   StallD, FlushD    hold / clear the F->D prediction register
//   StallE, FlushE    hold / clear the D->E prediction register
//   BranchTypeE       EX instruction is a conditional branch
//   BranchE           branch resolved taken
//   BranchTarget      resolved branch target
//   PredictedPC       predicted target for PCF (0 on a BTB miss)
//   PredictedF        predict taken at fetch
//   PredictedE        EX branch was correctly predicted taken
//   MispredictE       EX prediction was wrong; flush and redirect
//   CorrectPC         redirect PC when MispredictE is high
//   Ready             table sweep finished, predictor active
//   BrCount           branches retired through EX (wraps)
//   MissCount         mispredictions (wraps)
module branch_predict_ctrl #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PredictedPC,
  output logic        PredictedF,
  output logic        PredictedE,
  output logic        MispredictE,
  output logic [31:0] CorrectPC,
  output logic        Ready,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state, state_next;
  logic [IDX_W-1:0] ptr;

  // BTB storage
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [31:0]      tgt_mem [DEPTH];
  logic [1:0]       cnt_mem [DEPTH];

  // Prediction pipeline
  logic        taken_d, taken_e;
  logic [31:0] target_d, target_e;

  logic             run;
  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             upd;
  logic [1:0]       cnt_next;

  // PC bits [1:0] never index or tag the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) ptr <= ptr + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && ptr == '1) state_next = RUN;
  end

  assign run   = (state == RUN);
  assign Ready = run;

  // ------------------------------------------------------------- lookup
  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign hit_f = run & valid[idx_f] & (tag_mem[idx_f] == tag_f);

  assign PredictedF  = hit_f & cnt_mem[idx_f][1];
  assign PredictedPC = hit_f ? tgt_mem[idx_f] : '0;

  // --------------------------------------------------------- resolution
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign hit_e = valid[idx_e] & (tag_mem[idx_e] == tag_e);

  always_comb begin
    PredictedE  = run & taken_e & BranchTypeE & BranchE & (target_e == BranchTarget);
    MispredictE = run & ((BranchTypeE & ~PredictedE & (taken_e | BranchE)) |
                         (taken_e & ~BranchTypeE));
    CorrectPC   = (BranchTypeE & BranchE) ? BranchTarget : PCE + 32'd4;
    // rst_n gating keeps a branch sitting in EX during reset from writing.
    upd         = rst_n & run & BranchTypeE & ~StallE & ~FlushE;

    cnt_next = cnt_mem[idx_e];
    if (BranchE) begin
      if (cnt_mem[idx_e] != 2'b11) cnt_next = cnt_mem[idx_e] + 2'd1;
    end else begin
      if (cnt_mem[idx_e] != 2'b00) cnt_next = cnt_mem[idx_e] - 2'd1;
    end
  end

  // ------------------------------------------------- table sweep/update
  // Writes land at the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (rst_n && state == INIT) begin
      valid[ptr] <= 1'b0;
    end else if (upd) begin
      if (hit_e) begin
        cnt_mem[idx_e] <= cnt_next;
        if (BranchE) tgt_mem[idx_e] <= BranchTarget;
      end else if (BranchE) begin
        valid[idx_e]   <= 1'b1;
        tag_mem[idx_e] <= tag_e;
        tgt_mem[idx_e] <= BranchTarget;
        cnt_mem[idx_e] <= 2'b10;
      end
    end
  end

  // -------------------------------------------------- prediction pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_d  <= 1'b0;
      target_d <= '0;
      taken_e  <= 1'b0;
      target_e <= '0;
    end else begin
      if (FlushD) begin
        taken_d  <= 1'b0;
        target_d <= '0;
      end else if (!StallD) begin
        taken_d  <= PredictedF;
        target_d <= PredictedPC;
      end
      if (FlushE) begin
        taken_e  <= 1'b0;
        target_e <= '0;
      end else if (!StallE) begin
        taken_e  <= taken_d;
        target_e <= target_d;
      end
    end
  end

  // --------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else if (upd) begin
      BrCount <= BrCount + 32'd1;
      if (MispredictE) MissCount <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed testbench for branch_predict_ctrl. Stimulus pushes expected
// values tagged with the cycle they apply to; a negedge monitor pops and
// compares them against the DUT outputs.
module tb_branch_predict_ctrl;

  localparam int S_READY = 0;
  localparam int S_PF    = 1;
  localparam int S_PPC   = 2;
  localparam int S_PE    = 3;
  localparam int S_MIS   = 4;
  localparam int S_CPC   = 5;
  localparam int S_BR    = 6;
  localparam int S_MISS  = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF, PCE, BranchTarget;
  logic        StallD, FlushD, StallE, FlushE, BranchTypeE, BranchE;
  logic [31:0] PredictedPC, CorrectPC, BrCount, MissCount;
  logic        PredictedF, PredictedE, MispredictE, Ready;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PCE(PCE),
    .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
    .BranchTypeE(BranchTypeE), .BranchE(BranchE), .BranchTarget(BranchTarget),
    .PredictedPC(PredictedPC), .PredictedF(PredictedF), .PredictedE(PredictedE),
    .MispredictE(MispredictE), .CorrectPC(CorrectPC), .Ready(Ready),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_READY: return {31'b0, Ready};
      S_PF:    return {31'b0, PredictedF};
      S_PPC:   return PredictedPC;
      S_PE:    return {31'b0, PredictedE};
      S_MIS:   return {31'b0, MispredictE};
      S_CPC:   return CorrectPC;
      S_BR:    return BrCount;
      default: return MissCount;
    endcase
  endfunction

  // Monitor
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = pick(mon_e.sel);
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", mon_e.name, cyc, mon_act, mon_e.exp);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic counters(input logic [31:0] br, input logic [31:0] miss);
    chk("BrCount", S_BR, br);
    chk("MissCount", S_MISS, miss);
  endtask

  // Lookup at fetch, then one idle cycle so the prediction reaches EX.
  task automatic look(input logic [31:0] pc, input logic expf, input logic [31:0] exppc);
    PCF = pc; BranchTypeE = 1'b0; BranchE = 1'b0;
    chk("lookF", S_PF, {31'b0, expf});
    chk("lookPC", S_PPC, exppc);
    step();
    PCF = 32'h0;
    step();
  endtask

  task automatic resolve(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                         input logic pe, input logic mis, input logic [31:0] cpc);
    PCF = 32'h0; PCE = pce; BranchTypeE = 1'b1; BranchE = tk; BranchTarget = tgt;
    chk("PredictedE", S_PE, {31'b0, pe});
    chk("MispredictE", S_MIS, {31'b0, mis});
    chk("CorrectPC", S_CPC, cpc);
    step();
    BranchTypeE = 1'b0; BranchE = 1'b0;
  endtask

  task automatic sweep_check(input logic [31:0] pcf);
    PCF = pcf;
    for (int i = 0; i < 64; i++) begin
      chk("ReadyInit", S_READY, 32'd0);
      chk("PredFInit", S_PF, 32'd0);
      step();
    end
    chk("ReadyRise", S_READY, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; PCF = 32'h100; PCE = 32'h0; BranchTarget = 32'h0;
    StallD = 1'b0; FlushD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    BranchTypeE = 1'b0; BranchE = 1'b0;

    // Reset for two cycles
    step();
    chk("ReadyRst", S_READY, 32'd0);
    chk("PredFRst", S_PF, 32'd0);
    chk("PredPCRst", S_PPC, 32'd0);
    counters(32'd0, 32'd0);
    step();
    rst_n = 1'b1;

    // Sweep, with a taken branch in EX for the first half: must be ignored
    for (int i = 0; i < 64; i++) begin
      if (i < 32) begin
        PCE = 32'h300; BranchTypeE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h40;
        chk("MisInit", S_MIS, 32'd0);
        chk("PredEInit", S_PE, 32'd0);
      end else begin
        BranchTypeE = 1'b0; BranchE = 1'b0;
      end
      chk("ReadyInit", S_READY, 32'd0);
      chk("PredFInit", S_PF, 32'd0);
      step();
    end
    chk("ReadyRise", S_READY, 32'd1);
    counters(32'd0, 32'd0);
    look(32'h300, 1'b0, 32'h0);

    // First taken branch: allocate; same-cycle lookup still misses
    PCF = 32'h100; PCE = 32'h100; BranchTypeE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h80;
    chk("PredFSame", S_PF, 32'd0);
    chk("MisFirst", S_MIS, 32'd1);
    chk("CpcFirst", S_CPC, 32'h80);
    step();
    BranchTypeE = 1'b0; BranchE = 1'b0;
    counters(32'd1, 32'd1);
    look(32'h100, 1'b1, 32'h80);

    // Second taken execution: correctly predicted, cnt 10 -> 11
    resolve(32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80);
    counters(32'd2, 32'd1);

    // Hysteresis: 11 -> 10 still predicts taken, 10 -> 01 does not
    look(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 32'h104);
    counters(32'd3, 32'd2);
    look(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 32'h104);
    counters(32'd4, 32'd3);
    look(32'h100, 1'b0, 32'h80);

    // Down to 00, saturate, then climb back to 10
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104);
    counters(32'd5, 32'd3);
    look(32'h100, 1'b0, 32'h80);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104);
    counters(32'd6, 32'd3);
    look(32'h100, 1'b0, 32'h80);
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
    counters(32'd7, 32'd4);
    look(32'h100, 1'b0, 32'h80);
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
    counters(32'd8, 32'd5);
    look(32'h100, 1'b1, 32'h80);

    // Predicted taken but target differs: mispredict, target rewritten
    resolve(32'h100, 1'b1, 32'h90, 1'b0, 1'b1, 32'h90);
    counters(32'd9, 32'd6);
    look(32'h100, 1'b1, 32'h90);

    // StallE for 3 cycles with the branch in EX: one update only
    StallD = 1'b1; StallE = 1'b1;
    PCE = 32'h100; BranchTypeE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h90;
    for (int i = 0; i < 3; i++) begin
      chk("PredEStall", S_PE, 32'd1);
      chk("MisStall", S_MIS, 32'd0);
      counters(32'd9, 32'd6);
      step();
    end
    StallD = 1'b0; StallE = 1'b0;
    chk("PredERel", S_PE, 32'd1);
    step();
    BranchTypeE = 1'b0; BranchE = 1'b0;
    counters(32'd10, 32'd6);

    // FlushD beats StallD on a predicted-taken slot
    PCF = 32'h100; StallD = 1'b1; FlushD = 1'b1;
    chk("PredFFlD", S_PF, 32'd1);
    step();
    PCF = 32'h0; StallD = 1'b0; FlushD = 1'b0;
    step();
    chk("MisFlushD", S_MIS, 32'd0);

    // FlushE beats StallE; the flushed branch in EX must not update
    PCF = 32'h100;
    step();
    PCF = 32'h0; StallE = 1'b1; FlushE = 1'b1;
    PCE = 32'h400; BranchTypeE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h48;
    step();
    StallE = 1'b0; FlushE = 1'b0; BranchTypeE = 1'b0; BranchE = 1'b0;
    chk("MisFlushE", S_MIS, 32'd0);
    counters(32'd10, 32'd6);
    look(32'h400, 1'b0, 32'h0);

    // Conflict: 0x200 evicts 0x100; same-cycle lookup sees the old entry
    PCF = 32'h100; PCE = 32'h200; BranchTypeE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h44;
    chk("PredFOld", S_PF, 32'd1);
    chk("PredPCOld", S_PPC, 32'h90);
    chk("MisConf", S_MIS, 32'd1);
    chk("CpcConf", S_CPC, 32'h44);
    step();
    look(32'h100, 1'b0, 32'h0);
    counters(32'd11, 32'd7);
    look(32'h200, 1'b1, 32'h44);

    // Reset mid-operation, then again mid-sweep
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("ReadyRst2", S_READY, 32'd0);
    counters(32'd0, 32'd0);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sweep_check(32'h200);
    chk("MisAfter", S_MIS, 32'd0);
    look(32'h200, 1'b0, 32'h0);

    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
